// File: rtl/my_dmux_pkg.sv
// Shared constants, word type and slot-select decode for the registered 1-to-8 demux.
package my_dmux_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned SEL_W  = 3;

  typedef logic [15:0] word_t;

  function automatic logic [NUM_CH-1:0] onehot8(input logic [SEL_W-1:0] sel);
    logic [NUM_CH-1:0] mask;
    mask      = '0;
    mask[sel] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/my_dmux_slot.sv
// One-entry holding register with valid/ready handshake; one instance per demux channel.
module my_dmux_slot
  import my_dmux_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_free
);

  if (NUM_CH != 8) begin : g_bad_num_ch
    $fatal(1, "my_dmux_slot: NUM_CH must be 8");
  end

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Load wins over drain so a full slot that drains can refill in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_free  = !r_valid || i_ready;

endmodule

// File: rtl/my_dmux_16_8_way_reg.sv
// Registered 1-to-8 stream demux with broadcast; one holding slot per channel.
// Optional accepted-transfer counter (acc_count) enabled by MY_DMUX_16_8_WAY_REG_STATS_EN.
module my_dmux_16_8_way_reg
  import my_dmux_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic                 in_bcast,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_a,
  output logic [WIDTH-1:0]     out_b,
  output logic [WIDTH-1:0]     out_c,
  output logic [WIDTH-1:0]     out_d,
  output logic [WIDTH-1:0]     out_e,
  output logic [WIDTH-1:0]     out_f,
  output logic [WIDTH-1:0]     out_g,
  output logic [WIDTH-1:0]     out_h,
  output logic [NUM_CH-1:0]    out_valid,
`ifdef MY_DMUX_16_8_WAY_REG_STATS_EN
  output logic [15:0]          acc_count,
`endif
  input  logic [NUM_CH-1:0]    out_ready
);

  logic [NUM_CH-1:0] w_free;
  logic [NUM_CH-1:0] w_load;
  logic              w_accept;
  logic [WIDTH-1:0]  w_out [NUM_CH];

  // in_ready is gated by reset and never looks at in_valid.
  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      in_ready = in_bcast ? (&w_free) : w_free[in_sel];
    end
  end

  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_load = '0;
    if (w_accept) begin
      w_load = in_bcast ? {NUM_CH{1'b1}} : onehot8(in_sel);
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    my_dmux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load[k]),
      .i_data  (in_data),
      .i_ready (out_ready[k]),
      .o_valid (out_valid[k]),
      .o_data  (w_out[k]),
      .o_free  (w_free[k])
    );
  end

  assign out_a = w_out[0];
  assign out_b = w_out[1];
  assign out_c = w_out[2];
  assign out_d = w_out[3];
  assign out_e = w_out[4];
  assign out_f = w_out[5];
  assign out_g = w_out[6];
  assign out_h = w_out[7];

`ifdef MY_DMUX_16_8_WAY_REG_STATS_EN
  logic [15:0] r_acc_count;

  // A broadcast is a single transfer; the count wraps silently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc_count <= '0;
    end else if (w_accept) begin
      r_acc_count <= r_acc_count + 16'd1;
    end
  end

  assign acc_count = r_acc_count;
`endif

endmodule

// File: tb/tb_my_dmux_16_8_way_reg.sv
// Self-checking bench for my_dmux_16_8_way_reg: per-channel scoreboard queues plus directed checks.
module tb_my_dmux_16_8_way_reg;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic [2:0]  in_sel;
  logic        in_bcast;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_a, out_b, out_c, out_d, out_e, out_f, out_g, out_h;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
`ifdef MY_DMUX_16_8_WAY_REG_STATS_EN
  logic [15:0] acc_count;
`endif

  my_dmux_16_8_way_reg #(
    .WIDTH (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_bcast  (in_bcast),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_d     (out_d),
    .out_e     (out_e),
    .out_f     (out_f),
    .out_g     (out_g),
    .out_h     (out_h),
    .out_valid (out_valid),
`ifdef MY_DMUX_16_8_WAY_REG_STATS_EN
    .acc_count (acc_count),
`endif
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [15:0] obs [8];
  assign obs[0] = out_a;
  assign obs[1] = out_b;
  assign obs[2] = out_c;
  assign obs[3] = out_d;
  assign obs[4] = out_e;
  assign obs[5] = out_f;
  assign obs[6] = out_g;
  assign obs[7] = out_h;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: words pushed on accept, popped when the sink drains them.
  logic [15:0] sb_q [8][$];
  logic [7:0]  mv;
  logic [7:0]  fr;
  logic        er;
  logic        prev_stall = 1'b0;
  logic [19:0] prev_in;
  logic [15:0] m_cnt = 16'd0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rdy_in_reset", {31'd0, in_ready}, 32'd0);
      for (int k = 0; k < 8; k++) sb_q[k].delete();
      m_cnt      = 16'd0;
      prev_stall = 1'b0;
    end else begin
      for (int k = 0; k < 8; k++) mv[k] = (sb_q[k].size() != 0);
      chk("sb_valid", {24'd0, out_valid}, {24'd0, mv});
      for (int k = 0; k < 8; k++) begin
        if (mv[k]) chk($sformatf("sb_data%0d", k), {16'd0, obs[k]}, {16'd0, sb_q[k][0]});
      end
      fr = ~mv | out_ready;
      er = in_bcast ? (&fr) : fr[in_sel];
      chk("sb_ready", {31'd0, in_ready}, {31'd0, er});
      if (prev_stall) chk("src_hold", {12'd0, in_bcast, in_sel, in_data}, {12'd0, prev_in});
`ifdef MY_DMUX_16_8_WAY_REG_STATS_EN
      chk("sb_count", {16'd0, acc_count}, {16'd0, m_cnt});
`endif
      for (int k = 0; k < 8; k++) begin
        if (mv[k] && out_ready[k]) void'(sb_q[k].pop_front());
      end
      if (in_valid && er) begin
        for (int k = 0; k < 8; k++) begin
          if (in_bcast || in_sel == 3'(k)) sb_q[k].push_back(in_data);
        end
        m_cnt = m_cnt + 16'd1;
      end
      prev_stall = in_valid && !er;
      prev_in    = {in_bcast, in_sel, in_data};
    end
  end

  logic last_acc;

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    in_bcast  = 1'b0;
    in_valid  = 1'b0;
    out_ready = '0;

    // Reset state
    @(negedge clk);
    chk("rst_valid", {24'd0, out_valid}, 32'h00);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_a", {16'd0, out_a}, 32'h0);
    chk("rst_out_h", {16'd0, out_h}, 32'h0);
    tick();
    rst_n = 1'b1;

    // Single word to channel 3
    in_data = 16'h1234; in_sel = 3'd3; in_valid = 1'b1;
    @(negedge clk);
    chk("t1_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_valid", {24'd0, out_valid}, 32'h08);
    chk("t1_out_d", {16'd0, out_d}, 32'h1234);

    // Full slot stalls, then drain-and-load in one cycle
    tick();
    in_data = 16'hBEEF; in_sel = 3'd3; in_valid = 1'b1;
    @(negedge clk);
    chk("t2_stall", {31'd0, in_ready}, 32'd0);
    tick();
    @(negedge clk);
    chk("t2_hold_d", {16'd0, out_d}, 32'h1234);
    tick();
    out_ready = 8'h08;
    @(negedge clk);
    chk("t2_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0; out_ready = 8'h00;
    @(negedge clk);
    chk("t2_out_d", {16'd0, out_d}, 32'hBEEF);
    chk("t2_valid", {24'd0, out_valid}, 32'h08);
    tick();
    out_ready = 8'hFF;
    tick();
    out_ready = 8'h00;
    @(negedge clk);
    chk("t2_drain", {24'd0, out_valid}, 32'h00);

    // Fill all channels, ninth word stalls
    tick();
    for (int i = 0; i < 8; i++) begin
      in_data = 16'(i); in_sel = 3'(i); in_valid = 1'b1;
      tick();
    end
    in_data = 16'h0008; in_sel = 3'd5;
    @(negedge clk);
    chk("t3_full", {24'd0, out_valid}, 32'hFF);
    chk("t3_stall", {31'd0, in_ready}, 32'd0);
    tick();
    out_ready = 8'h20;
    @(negedge clk);
    chk("t3_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0; out_ready = 8'h00;
    @(negedge clk);
    chk("t3_out_f", {16'd0, out_f}, 32'h0008);
    chk("t3_out_c", {16'd0, out_c}, 32'h0002);
    tick();
    out_ready = 8'hFF;
    tick();
    out_ready = 8'h00;

    // Broadcast into empty slots, then blocked by one full slot
    in_data = 16'hA5A5; in_bcast = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("t4_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0; in_bcast = 1'b0;
    @(negedge clk);
    chk("t4_valid", {24'd0, out_valid}, 32'hFF);
    for (int k = 0; k < 8; k++) chk($sformatf("t4_out%0d", k), {16'd0, obs[k]}, 32'hA5A5);
    tick();
    out_ready = 8'hBF;
    tick();
    out_ready = 8'h00;
    @(negedge clk);
    chk("t4_only6", {24'd0, out_valid}, 32'h40);
    tick();
    in_data = 16'h5A5A; in_bcast = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("t4_stall", {31'd0, in_ready}, 32'd0);
    tick();
    @(negedge clk);
    chk("t4_nowrite", {24'd0, out_valid}, 32'h40);
    chk("t4_keep_a", {16'd0, out_a}, 32'hA5A5);
    tick();
    out_ready = 8'h40;
    @(negedge clk);
    chk("t4_release", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0; in_bcast = 1'b0; out_ready = 8'h00;
    @(negedge clk);
    chk("t4_full", {24'd0, out_valid}, 32'hFF);
    chk("t4_out_c", {16'd0, out_c}, 32'h5A5A);

    // Reset while full with a pending word
    tick();
    in_data = 16'h7777; in_sel = 3'd0; in_valid = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    chk("t5_ready", {31'd0, in_ready}, 32'd0);
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("t5_valid", {24'd0, out_valid}, 32'h00);
    chk("t5_out_a", {16'd0, out_a}, 32'h0);
    chk("t5_out_h", {16'd0, out_h}, 32'h0);

    // Random traffic, source holds each word until accepted
    tick();
    last_acc = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = 16'($urandom);
        in_sel   = 3'($urandom);
        in_bcast = ($urandom_range(0, 7) == 0);
      end
      out_ready = 8'($urandom);
      @(negedge clk);
      last_acc = in_valid && in_ready;
      tick();
    end
    in_valid = 1'b0;

`ifdef MY_DMUX_16_8_WAY_REG_STATS_EN
    // Counter wrap: 65534 accepts, then one plain and one broadcast accept
    rst_n = 1'b0; in_bcast = 1'b0;
    tick();
    rst_n = 1'b1; out_ready = 8'hFF;
    for (int i = 0; i < 65534; i++) begin
      in_data = 16'(i); in_sel = 3'(i); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("cnt_fffe", {16'd0, acc_count}, 32'hFFFE);
    tick();
    in_data = 16'h1111; in_sel = 3'd2; in_valid = 1'b1;
    tick();
    in_data = 16'h2222; in_bcast = 1'b1;
    tick();
    in_valid = 1'b0; in_bcast = 1'b0;
    @(negedge clk);
    chk("cnt_wrap", {16'd0, acc_count}, 32'h0000);
`endif

    tick();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
